// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between host pixel
// writes and row prefetches into a VGA line buffer. A row fetch always has
// priority; host writes are only accepted while the fetch path is idle.
module vga_fb_arbiter #(
    parameter int LINE_PIX = 160,
    parameter int ROWS     = 120,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_req,
    input  logic [9:0]        line_num,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              lb_we,
    output logic [7:0]        lb_addr,
    output logic [7:0]        lb_data,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              overrun,
    output logic              addr_err
);

    localparam logic [7:0]        ROWS_L   = 8'(ROWS);
    localparam logic [7:0]        CNT_LAST = 8'(LINE_PIX - 1);
    localparam logic [ADDR_W-1:0] PIX_L    = ADDR_W'(LINE_PIX);
    localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(LINE_PIX * ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_d;
    logic              pend, pend_d;
    logic [7:0]        row, row_d;
    logic [7:0]        cnt, cnt_d;

    logic              wr_accept;
    logic              wr_in_range;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              addr_err_q;
    logic              lb_we_q;
    logic [7:0]        lb_addr_q;
    logic              fetch_done_q;
    logic              overrun_q;
    logic [ADDR_W-1:0] fetch_addr;

    assign wr_ready    = (state == IDLE) && !pend && !line_req;
    assign wr_accept   = wr_valid && wr_ready;
    assign wr_in_range = wr_addr < FB_WORDS;
    assign fetch_busy  = (state != IDLE);
    assign fetch_addr  = ADDR_W'(row) * PIX_L + ADDR_W'(cnt);

    // State, pending-request flag, latched row and pixel counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pend  <= 1'b0;
            row   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            pend  <= pend_d;
            row   <= row_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state: latch a request, launch or discard it, walk the row, drain
    always_comb begin
        state_d = state;
        pend_d  = pend;
        row_d   = row;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (pend) begin
                    pend_d = 1'b0;
                    if (row < ROWS_L) begin
                        state_d = FETCH;
                        cnt_d   = '0;
                    end
                end else if (line_req) begin
                    pend_d = 1'b1;
                    row_d  = line_num[9:2];
                end
            end
            FETCH: begin
                cnt_d = cnt + 8'd1;
                if (cnt == CNT_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered host write slot, address-error pulse and fetch status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            addr_err_q   <= 1'b0;
            lb_we_q      <= 1'b0;
            lb_addr_q    <= '0;
            fetch_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            wr_en_q      <= wr_accept && wr_in_range;
            addr_err_q   <= wr_accept && !wr_in_range;
            if (wr_accept) begin
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
            end
            lb_we_q      <= (state == FETCH);
            if (state == FETCH) begin
                lb_addr_q <= cnt;
            end
            fetch_done_q <= (state == DRAIN);
            overrun_q    <= overrun_q || (line_req && (fetch_busy || pend));
        end
    end

    // A write is only ever accepted in IDLE without a pending request, so the
    // registered write slot can never coincide with a FETCH read cycle.
    always_comb begin
        mem_en    = wr_en_q;
        mem_we    = wr_en_q;
        mem_addr  = wr_addr_q;
        mem_wdata = wr_data_q;
        if (state == FETCH) begin
            mem_en   = 1'b1;
            mem_we   = 1'b0;
            mem_addr = fetch_addr;
        end
    end

    // RAM read data arrives in the cycle after the read, so it is forwarded
    // straight to the line buffer and gated to keep lb_data quiet otherwise.
    assign lb_we      = lb_we_q;
    assign lb_addr    = lb_addr_q;
    assign lb_data    = lb_we_q ? mem_rdata : '0;
    assign fetch_done = fetch_done_q;
    assign overrun    = overrun_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: external RAM model, shadow framebuffer and a
// timeline-based expectation of each fetch computed from the request cycle.
module tb_vga_fb_arbiter;

    logic        clk;
    logic        reset;
    logic        line_req;
    logic [9:0]  line_num;
    logic        wr_valid;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        lb_we;
    logic [7:0]  lb_addr;
    logic [7:0]  lb_data;
    logic        fetch_busy;
    logic        fetch_done;
    logic        overrun;
    logic        addr_err;

    int checks = 0;
    int errors = 0;
    bit ovr_exp = 1'b0;

    logic [7:0]  ram    [0:32767];
    logic [7:0]  fb_ref [0:19199];
    logic [14:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    logic [45:0] allv;

    vga_fb_arbiter #(
        .LINE_PIX(160),
        .ROWS    (120),
        .ADDR_W  (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .line_req  (line_req),
        .line_num  (line_num),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .lb_we     (lb_we),
        .lb_addr   (lb_addr),
        .lb_data   (lb_data),
        .fetch_busy(fetch_busy),
        .fetch_done(fetch_done),
        .overrun   (overrun),
        .addr_err  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    assign allv = {mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_data,
                   fetch_busy, fetch_done, overrun, addr_err};

    task automatic test_reset();
        reset = 1'b0; line_req = 1'b0; line_num = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (allv !== 46'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", allv);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Back-to-back host writes from wq_addr/wq_data, one per cycle
    task automatic host_burst();
        int n;
        logic [14:0] pa;
        logic [7:0]  pd;
        bit inr;
        n = wq_addr.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                wr_valid = 1'b1; wr_addr = wq_addr[i]; wr_data = wq_data[i];
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clk);
            if (i < n) begin
                checks++;
                if (wr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_ready_burst[%0d]: got %b expected 1", i, wr_ready);
                end
            end
            if (i > 0) begin
                pa  = wq_addr[i-1];
                pd  = wq_data[i-1];
                inr = int'(pa) < 19200;
                checks++;
                if (mem_en !== inr || mem_we !== inr) begin
                    errors++;
                    $display("FAIL wr_strobe[%0d]: got en=%b we=%b expected %b", i-1, mem_en, mem_we, inr);
                end
                checks++;
                if (addr_err !== !inr) begin
                    errors++;
                    $display("FAIL addr_err[%0d]: got %b expected %b", i-1, addr_err, !inr);
                end
                if (inr) begin
                    checks++;
                    if (mem_addr !== pa || mem_wdata !== pd) begin
                        errors++;
                        $display("FAIL wr_payload[%0d]: got %0d/%h expected %0d/%h", i-1, mem_addr, mem_wdata, pa, pd);
                    end
                    fb_ref[int'(pa)] = pd;
                end
            end
            @(posedge clk); #1;
        end
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic fill_row(input int r);
        for (int k = 0; k < 160; k++) begin
            wq_addr.push_back(15'(r * 160 + k));
            wq_data.push_back(8'($urandom));
        end
        host_burst();
    endtask

    task automatic test_host_writes();
        for (int i = 5; i <= 7; i++) begin
            wq_addr.push_back(15'(i));
            wq_data.push_back(8'($urandom));
        end
        wq_addr.push_back(15'd19200);
        wq_data.push_back(8'($urandom));
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) wq_addr.push_back(15'($urandom_range(19200, 32767)));
            else                           wq_addr.push_back(15'($urandom_range(0, 19199)));
            wq_data.push_back(8'($urandom));
        end
        host_burst();
    endtask

    // One row request at relative cycle 0; optional second request and a
    // host write raised alongside it. Expectations follow the timeline:
    // pend at 1, reads 2..161, line-buffer writes 3..162, done at 163.
    task automatic run_fetch(input logic [9:0] ln, input int second_at, input bit with_wr,
                             input logic [14:0] waddr, input logic [7:0] wdata);
        int row_i, base, blocked_end, wacc;
        int rd_seen, lb_seen, busy_seen, done_seen;
        bit valid, w_inr, exp_rd, exp_wr, exp_lb;
        row_i       = int'(ln) / 4;
        valid       = row_i < 120;
        base        = row_i * 160;
        blocked_end = valid ? 162 : 1;
        wacc        = with_wr ? blocked_end + 1 : -1;
        w_inr       = int'(waddr) < 19200;
        rd_seen = 0; lb_seen = 0; busy_seen = 0; done_seen = 0;
        for (int c = 0; c < 168; c++) begin
            line_req = (c == 0) || (c == second_at);
            line_num = (c == 0) ? ln : 10'($urandom_range(0, 1023));
            wr_valid = with_wr && (c <= wacc);
            wr_addr  = waddr;
            wr_data  = wdata;
            @(negedge clk);
            if (second_at >= 0 && c == second_at + 1) ovr_exp = 1'b1;
            exp_rd = valid && c >= 2 && c <= 161;
            exp_wr = with_wr && w_inr && c == wacc + 1;
            exp_lb = valid && c >= 3 && c <= 162;
            checks++;
            if (mem_en !== (exp_rd || exp_wr) || mem_we !== exp_wr) begin
                errors++;
                $display("FAIL mem_strobe@%0d: got en=%b we=%b expected en=%b we=%b", c, mem_en, mem_we, exp_rd || exp_wr, exp_wr);
            end
            if (exp_rd) begin
                checks++;
                if (mem_addr !== 15'(base + c - 2)) begin
                    errors++;
                    $display("FAIL rd_addr@%0d: got %0d expected %0d", c, mem_addr, base + c - 2);
                end
            end
            if (exp_wr) begin
                checks++;
                if (mem_addr !== waddr || mem_wdata !== wdata) begin
                    errors++;
                    $display("FAIL late_write@%0d: got %0d/%h expected %0d/%h", c, mem_addr, mem_wdata, waddr, wdata);
                end
            end
            checks++;
            if (lb_we !== exp_lb) begin
                errors++;
                $display("FAIL lb_we@%0d: got %b expected %b", c, lb_we, exp_lb);
            end
            if (exp_lb) begin
                checks++;
                if (lb_addr !== 8'(c - 3) || lb_data !== fb_ref[base + c - 3]) begin
                    errors++;
                    $display("FAIL lb_write@%0d: got %0d/%h expected %0d/%h", c, lb_addr, lb_data, c - 3, fb_ref[base + c - 3]);
                end
            end
            checks++;
            if (fetch_busy !== (valid && c >= 2 && c <= 162) || fetch_done !== (valid && c == 163)) begin
                errors++;
                $display("FAIL busy_done@%0d: got %b%b expected %b%b", c, fetch_busy, fetch_done, valid && c >= 2 && c <= 162, valid && c == 163);
            end
            checks++;
            if (overrun !== ovr_exp) begin
                errors++;
                $display("FAIL overrun@%0d: got %b expected %b", c, overrun, ovr_exp);
            end
            checks++;
            if (addr_err !== (with_wr && !w_inr && c == wacc + 1)) begin
                errors++;
                $display("FAIL addr_err@%0d: got %b expected %b", c, addr_err, with_wr && !w_inr && c == wacc + 1);
            end
            if (with_wr && c <= wacc) begin
                checks++;
                if (wr_ready !== (c == wacc)) begin
                    errors++;
                    $display("FAIL wr_ready@%0d: got %b expected %b", c, wr_ready, c == wacc);
                end
            end
            if (lb_we) lb_seen++;
            if (fetch_busy) busy_seen++;
            if (fetch_done) done_seen++;
            if (mem_en && !mem_we) rd_seen++;
            @(posedge clk); #1;
        end
        line_req = 1'b0;
        wr_valid = 1'b0;
        checks++;
        if (lb_seen != (valid ? 160 : 0) || rd_seen != (valid ? 160 : 0)) begin
            errors++;
            $display("FAIL fetch_counts: got lb=%0d rd=%0d expected %0d", lb_seen, rd_seen, valid ? 160 : 0);
        end
        checks++;
        if (busy_seen != (valid ? 161 : 0) || done_seen != (valid ? 1 : 0)) begin
            errors++;
            $display("FAIL busy_len: got busy=%0d done=%0d expected %0d/%0d", busy_seen, done_seen, valid ? 161 : 0, valid ? 1 : 0);
        end
        if (with_wr && w_inr) fb_ref[int'(waddr)] = wdata;
    endtask

    task automatic test_fetch_line8();
        fill_row(2);
        run_fetch(10'd8, -1, 1'b0, '0, '0);
    endtask

    task automatic test_fetch_random();
        logic [9:0] ln;
        for (int i = 0; i < 3; i++) begin
            ln = 10'($urandom_range(0, 479));
            fill_row(int'(ln) / 4);
            run_fetch(ln, -1, 1'b0, '0, '0);
        end
    endtask

    task automatic test_fetch_with_write();
        logic [9:0] ln;
        ln = 10'($urandom_range(0, 479));
        fill_row(int'(ln) / 4);
        run_fetch(ln, -1, 1'b1, 15'($urandom_range(0, 19199)), 8'($urandom));
    endtask

    task automatic test_overrun();
        logic [9:0] ln;
        ln = 10'($urandom_range(0, 479));
        fill_row(int'(ln) / 4);
        run_fetch(ln, 22, 1'b0, '0, '0);
    endtask

    task automatic test_bad_row();
        run_fetch(10'd480, -1, 1'b1, 15'd19200, 8'($urandom));
        run_fetch(10'($urandom_range(480, 1023)), 1, 1'b1, 15'($urandom_range(0, 19199)), 8'($urandom));
    endtask

    task automatic test_reset_midfetch();
        logic [9:0] ln;
        ln = 10'($urandom_range(0, 479));
        fill_row(int'(ln) / 4);
        line_req = 1'b1;
        line_num = ln;
        for (int c = 0; c < 52; c++) begin
            @(posedge clk); #1;
            line_req = 1'b0;
        end
        checks++;
        if (lb_we !== 1'b1 || fetch_busy !== 1'b1) begin
            errors++;
            $display("FAIL midfetch_active: got lb_we=%b busy=%b expected 1/1", lb_we, fetch_busy);
        end
        reset = 1'b0;
        #1;
        ovr_exp = 1'b0;
        checks++;
        if (allv !== 46'd0) begin
            errors++;
            $display("FAIL reset_abort: got %h expected 0", allv);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (allv !== 46'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected 0", c, allv);
            end
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        ln = 10'($urandom_range(0, 479));
        fill_row(int'(ln) / 4);
        run_fetch(ln, -1, 1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_host_writes();
        test_fetch_line8();
        test_fetch_random();
        test_fetch_with_write();
        test_overrun();
        test_bad_row();
        test_reset_midfetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
